// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if
//   Groups the signals between the mul/div sequencer, the pipeline's DX
//   latch, the external multi-cycle multiplier/divider and the writeback
//   arbiter.
//
//   Handshake semantics (valid/ready):
//     - dx_valid qualifies dx_insn/dx_a/dx_b; a non-valid DX is a bubble.
//     - md_mult/md_div are one-cycle start strobes; md_opA/md_opB are held
//       stable until the unit answers with a one-cycle md_rdy, which also
//       qualifies md_result and md_exception.
//     - wb_req is the valid, wb_gnt the ready: wb_reg/wb_data stay stable
//       while wb_req is high, and the write happens in the cycle where
//       wb_req and wb_gnt are both high.
//
//   Modports:
//     master : the sequencer (drives strobes, stall/kill, write request)
//     slave  : pipeline / unit / arbiter side
interface multdiv_sequencer_if;
    logic [31:0] dx_insn;
    logic        dx_valid;
    logic [31:0] dx_a;
    logic [31:0] dx_b;
    logic        md_mult;
    logic        md_div;
    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_rdy;
    logic        stall;
    logic        dx_kill;
    logic        wb_req;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_gnt;
    logic        busy;

    modport master (
        input  dx_insn, dx_valid, dx_a, dx_b,
        input  md_result, md_exception, md_rdy, wb_gnt,
        output md_mult, md_div, md_opA, md_opB,
        output stall, dx_kill, wb_req, wb_reg, wb_data, busy
    );

    modport slave (
        output dx_insn, dx_valid, dx_a, dx_b,
        output md_result, md_exception, md_rdy, wb_gnt,
        input  md_mult, md_div, md_opA, md_opB,
        input  stall, dx_kill, wb_req, wb_reg, wb_data, busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Shares one external multi-cycle multiplier/divider with the 5-stage
//   pipeline. A mul/div seen in DX is latched, the unit is started with a
//   one-cycle strobe, the front of the pipeline is frozen until the result
//   returns, and the result (or an r30 exception code) is written through
//   the writeback arbiter. A hung unit is abandoned after TIMEOUT cycles.
//
//   Ports:
//     clock     : rising-edge clock
//     reset     : synchronous, active-high
//     bus       : multdiv_sequencer_if.master (DX, unit and writeback signals)
//     dbg_state : current FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//
//   Optional feature macro: MULTDIV_FASTPATH_EN
//     When defined, ops with a zero operand finish without using the unit.
module multdiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_sequencer_if.master  bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [31:0]       op_a, op_b, result;
    logic [4:0]        rd;
    logic              is_div, exc;
    logic [CNT_W-1:0]  cnt;

    logic detect, insn_div, fast_take, fast_exc, timeout, skip_write;
    logic unused_insn_bits;

    assign insn_div = (bus.dx_insn[6:2] == 5'b00111);
    assign detect   = bus.dx_valid && (bus.dx_insn[31:27] == 5'b00000) &&
                      ((bus.dx_insn[6:2] == 5'b00110) || insn_div);

    // Fields of the instruction word this block never looks at.
    assign unused_insn_bits = ^{bus.dx_insn[21:7], bus.dx_insn[1:0]};

`ifdef MULTDIV_FASTPATH_EN
    // Any zero operand makes the answer known up front: 0, or divide-by-zero.
    assign fast_take = (bus.dx_a == 32'd0) || (bus.dx_b == 32'd0);
    assign fast_exc  = insn_div && (bus.dx_b == 32'd0);
`else
    assign fast_take = 1'b0;
    assign fast_exc  = 1'b0;
`endif

    // The counter is 0 in the first WAIT cycle, so it reaches TIMEOUT at the
    // same edge DONE is entered: WAIT lasts at most TIMEOUT cycles.
    assign timeout    = (cnt == CNT_W'(TIMEOUT - 1));
    assign skip_write = (rd == 5'd0) && !exc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            rd     <= '0;
            is_div <= 1'b0;
            exc    <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (detect) begin
                        op_a   <= bus.dx_a;
                        op_b   <= bus.dx_b;
                        rd     <= bus.dx_insn[26:22];
                        is_div <= insn_div;
                        result <= '0;
                        exc    <= fast_exc;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A result arriving on the timeout cycle still counts.
                    if (bus.md_rdy) begin
                        result <= bus.md_result;
                        exc    <= bus.md_exception;
                    end else if (timeout) begin
                        exc    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        bus.md_mult = 1'b0;
        bus.md_div  = 1'b0;
        bus.stall   = 1'b0;
        bus.dx_kill = 1'b0;
        bus.wb_req  = 1'b0;
        bus.wb_reg  = 5'd0;
        bus.wb_data = 32'd0;
        case (state)
            IDLE: begin
                bus.stall = detect;
                if (detect) state_next = fast_take ? DONE : ISSUE;
            end
            ISSUE: begin
                bus.md_mult = !is_div;
                bus.md_div  = is_div;
                bus.stall   = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                bus.stall = 1'b1;
                if (bus.md_rdy || timeout) state_next = DONE;
            end
            DONE: begin
                if (skip_write) begin
                    // r0 is never written; just retire the DX op.
                    bus.dx_kill = 1'b1;
                    state_next  = IDLE;
                end else begin
                    bus.wb_req  = 1'b1;
                    bus.wb_reg  = exc ? 5'd30 : rd;
                    bus.wb_data = exc ? (is_div ? 32'd5 : 32'd4) : result;
                    if (bus.wb_gnt) begin
                        bus.dx_kill = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        bus.stall   = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.md_opA = op_a;
    assign bus.md_opB = op_b;
    assign bus.busy   = (state != IDLE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer
//   Directed bench for multdiv_sequencer. Each operation is described by a
//   small record (kind, rd, operands, unit latency, result, grant delay).
//   A transaction-level model turns that record into the expected output
//   vector for every cycle counted from detection; a compare process checks
//   the DUT against that queue each cycle, and a few literal checks per
//   operation pin the model to hand-computed numbers.
module tb_multdiv_sequencer;

    localparam int W = 107;

    typedef struct {
        bit          dv;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;    // cycles from strobe to md_rdy; 0 = never
        logic [31:0] res;
        bit          exc;
        int          gdly;   // DONE cycles before wb_gnt
        bit          tie;    // wb_gnt held high all the time
        bit          spur;   // stray md_rdy during ISSUE
        int          rst_k;  // cycle reset is asserted; -1 = none
        int          tail;   // idle cycles after the operation
    } op_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] dbg_state;

    multdiv_sequencer_if bus();

    multdiv_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cur_test = 0;
    int cur_k = 0;
    logic [31:0] prev_a = 32'd0;
    logic [31:0] prev_b = 32'd0;
    logic [W-1:0] exp_q[$];

    int          rec_wb_first_k, rec_wb_cycles, rec_kill, rec_strobe;
    logic [4:0]  rec_wb_reg;
    logic [31:0] rec_wb_data;

    function automatic logic [W-1:0] pack(bit m, bit d, logic [31:0] a, logic [31:0] b,
                                          bit st, bit k, bit rq, logic [4:0] r,
                                          logic [31:0] dt, bit bz);
        return {m, d, a, b, st, k, rq, r, dt, bz};
    endfunction

    function automatic op_t mk(bit dv, logic [4:0] rd, logic [31:0] a, logic [31:0] b,
                               int lat, logic [31:0] res, bit exc, int gdly, bit tie,
                               bit spur, int rst_k, int tail);
        op_t o;
        o.dv = dv; o.rd = rd; o.a = a; o.b = b; o.lat = lat; o.res = res;
        o.exc = exc; o.gdly = gdly; o.tie = tie; o.spur = spur;
        o.rst_k = rst_k; o.tail = tail;
        return o;
    endfunction

    function automatic logic [31:0] insn(op_t o);
        // opcode 0, rd, rs=1, rt=2, shamt 0, ALU op mul=6 / div=7
        return {5'b00000, o.rd, 5'd1, 5'd2, 5'd0, (o.dv ? 5'b00111 : 5'b00110), 2'b00};
    endfunction

    function automatic bit is_fast(op_t o);
`ifdef MULTDIV_FASTPATH_EN
        return (o.a == 32'd0) || (o.b == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Cycle (from detect) at which the write slot phase begins.
    function automatic int done_k(op_t o);
        if (is_fast(o)) return 1;
        if (o.lat == 0) return 42;   // strobe at 1, 40 WAIT cycles at 2..41
        return 2 + o.lat;
    endfunction

    function automatic bit final_exc(op_t o);
        if (is_fast(o)) return o.dv && (o.b == 32'd0);
        if (o.lat == 0) return 1'b1;
        return o.exc;
    endfunction

    function automatic bit skips(op_t o);
        return (o.rd == 5'd0) && !final_exc(o);
    endfunction

    function automatic int end_k(op_t o);
        return skips(o) ? done_k(o) : done_k(o) + o.gdly;
    endfunction

    function automatic logic [W-1:0] model(op_t o, int k);
        int d, e;
        bit ex;
        logic [4:0] r;
        logic [31:0] dt;
        d  = done_k(o);
        e  = end_k(o);
        ex = final_exc(o);
        r  = ex ? 5'd30 : o.rd;
        dt = ex ? (o.dv ? 32'd5 : 32'd4) : (is_fast(o) ? 32'd0 : o.res);
        if (o.rst_k >= 0 && k > o.rst_k)
            return pack(0, 0, 32'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0, 0);
        if (k == 0)
            return pack(0, 0, prev_a, prev_b, 1, 0, 0, 5'd0, 32'd0, 0);
        if (k > e)
            return pack(0, 0, o.a, o.b, 0, 0, 0, 5'd0, 32'd0, 0);
        if (!is_fast(o) && k == 1)
            return pack(!o.dv, o.dv, o.a, o.b, 1, 0, 0, 5'd0, 32'd0, 1);
        if (k < d)
            return pack(0, 0, o.a, o.b, 1, 0, 0, 5'd0, 32'd0, 1);
        if (skips(o))
            return pack(0, 0, o.a, o.b, 0, 1, 0, 5'd0, 32'd0, 1);
        return pack(0, 0, o.a, o.b, (k != e), (k == e), 1, r, dt, 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic run_op(input op_t o, input int id);
        int d, e, n;
        bit rdy_now, spur_now;
        d = done_k(o);
        e = end_k(o);
        n = (o.rst_k >= 0) ? o.rst_k + o.tail : e + 1 + o.tail;
        cur_test = id;
        rec_wb_first_k = -1; rec_wb_cycles = 0; rec_kill = 0; rec_strobe = 0;
        rec_wb_reg = '0; rec_wb_data = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            cur_k = k;
            reset = (o.rst_k >= 0 && k == o.rst_k);
            bus.dx_valid = !(o.rst_k >= 0 && k > o.rst_k) && (k <= e);
            bus.dx_insn  = insn(o);
            bus.dx_a     = o.a;
            bus.dx_b     = o.b;
            rdy_now  = (o.lat > 0) && (k == 1 + o.lat);
            spur_now = o.spur && (k == 1);
            bus.md_rdy       = rdy_now || spur_now;
            bus.md_result    = rdy_now ? o.res : (spur_now ? 32'hDEAD_BEEF : $urandom());
            bus.md_exception = rdy_now ? o.exc : spur_now;
            bus.wb_gnt       = o.tie ? 1'b1 : (k == d + o.gdly);
            exp_q.push_back(model(o, k));
        end
        if (o.rst_k >= 0) begin
            prev_a = 32'd0; prev_b = 32'd0;
        end else begin
            prev_a = o.a; prev_b = o.b;
        end
    endtask

    always @(negedge clock) begin
        logic [W-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = pack(bus.md_mult, bus.md_div, bus.md_opA, bus.md_opB, bus.stall,
                     bus.dx_kill, bus.wb_req, bus.wb_reg, bus.wb_data, bus.busy);
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle test=%0d k=%0d got=%h expected=%h", cur_test, cur_k, a, e);
            end
            if (bus.wb_req === 1'b1) begin
                if (rec_wb_first_k < 0) rec_wb_first_k = cur_k;
                rec_wb_cycles++;
                rec_wb_reg  = bus.wb_reg;
                rec_wb_data = bus.wb_data;
            end
            if (bus.dx_kill === 1'b1) rec_kill++;
            if (bus.md_mult === 1'b1 || bus.md_div === 1'b1) rec_strobe++;
        end
    end

    initial begin
        bus.dx_insn = '0; bus.dx_valid = 1'b0; bus.dx_a = '0; bus.dx_b = '0;
        bus.md_result = '0; bus.md_exception = 1'b0; bus.md_rdy = 1'b0; bus.wb_gnt = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            exp_q.push_back(pack(0, 0, 32'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0, 0));
        end
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;

        // 1: mul r3 = 6*7, unit answers after 17 cycles, grant tied high,
        //    stray md_rdy during ISSUE must be ignored.
        run_op(mk(0, 5'd3, 32'd6, 32'd7, 17, 32'd42, 0, 0, 1, 1, -1, 2), 1);
        check("t1_wb_reg", {27'd0, rec_wb_reg}, 32'd3);
        check("t1_wb_data", rec_wb_data, 32'd42);
        check("t1_wb_first", rec_wb_first_k, 32'd19);
        check("t1_strobes", rec_strobe, 32'd1);
        check("t1_kills", rec_kill, 32'd1);

        // 2: div 100/0, unit flags exception -> r30 = 5
        run_op(mk(1, 5'd9, 32'd100, 32'd0, 5, 32'd0, 1, 2, 0, 0, -1, 2), 2);
        check("t2_wb_reg", {27'd0, rec_wb_reg}, 32'd30);
        check("t2_wb_data", rec_wb_data, 32'd5);

        // 3: mul with a hung unit -> timeout after 40 WAIT cycles, r30 = 4
        run_op(mk(0, 5'd4, 32'd5, 32'd9, 0, 32'd0, 0, 1, 0, 0, -1, 2), 3);
        check("t3_wb_reg", {27'd0, rec_wb_reg}, 32'd30);
        check("t3_wb_data", rec_wb_data, 32'd4);
        check("t3_wb_first", rec_wb_first_k, 32'd42);

        // 4: mul r0 = 2*2 -> no write, one kill
        run_op(mk(0, 5'd0, 32'd2, 32'd2, 3, 32'd4, 0, 0, 0, 0, -1, 2), 4);
        check("t4_wb_cycles", rec_wb_cycles, 32'd0);
        check("t4_kills", rec_kill, 32'd1);

        // 5: reset during WAIT, unit answers afterwards -> nothing happens
        run_op(mk(0, 5'd7, 32'd11, 32'd13, 11, 32'd143, 0, 0, 0, 0, 10, 6), 5);
        check("t5_wb_cycles", rec_wb_cycles, 32'd0);
        check("t5_kills", rec_kill, 32'd0);

        // 6: div 1000/7 = 142, grant held off 5 cycles
        run_op(mk(1, 5'd12, 32'd1000, 32'd7, 9, 32'd142, 0, 5, 0, 0, -1, 2), 6);
        check("t6_wb_cycles", rec_wb_cycles, 32'd6);
        check("t6_wb_data", rec_wb_data, 32'd142);
        check("t6_wb_reg", {27'd0, rec_wb_reg}, 32'd12);

        // 7: mul overflow exception -> r30 = 4, stray md_rdy in ISSUE
        run_op(mk(0, 5'd5, 32'h7FFF_FFFF, 32'd2, 4, 32'hFFFF_FFFE, 1, 0, 0, 1, -1, 2), 7);
        check("t7_wb_data", rec_wb_data, 32'd4);

        // 8-10: back-to-back, each next op enters DX 2 cycles after the kill
        run_op(mk(1, 5'd1, 32'd0, 32'd5, 2, 32'd0, 0, 0, 1, 0, -1, 1), 8);
        check("t8_wb_data", rec_wb_data, 32'd0);
        run_op(mk(0, 5'd31, 32'd3, 32'd0, 1, 32'd0, 0, 0, 1, 0, -1, 1), 9);
        check("t9_wb_reg", {27'd0, rec_wb_reg}, 32'd31);
        run_op(mk(1, 5'd8, 32'd9, 32'd0, 6, 32'd0, 1, 1, 0, 0, -1, 3), 10);
        check("t10_wb_data", rec_wb_data, 32'd5);

        @(negedge clock); #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Sequencing controller that shares one external multi-cycle multiplier/divider with the 5-stage pipeline.
- Detects mul/div in the execute stage (DX latch), latches its operands and destination, and pulses the external unit's start strobe.
- Freezes the front of the pipeline until the result is back, then requests a regfile write slot from the writeback arbiter.
- Handles divide-by-zero/overflow exceptions (rstatus r30) and a hung-unit timeout.

Parameters:
- TIMEOUT, 40, WAIT-state cycles allowed before the operation is forced to complete as an exception.
- CNT_W, 6, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- dx_insn  in  32  instruction currently in the DX latch.
- dx_valid  in  1  DX holds a real (non-bubble) instruction.
- dx_a  in  32  rs operand from the DX latch, bypassed.
- dx_b  in  32  rt operand from the DX latch, bypassed.
- md_mult  out  1  one-cycle start strobe for multiply.
- md_div  out  1  one-cycle start strobe for divide.
- md_opA  out  32  latched operand A, held stable from ISSUE through WAIT.
- md_opB  out  32  latched operand B, held stable from ISSUE through WAIT.
- md_result  in  32  result from the unit.
- md_exception  in  1  unit flagged overflow or divide-by-zero; valid with md_rdy.
- md_rdy  in  1  result valid pulse.
- stall  out  1  freeze PC, FD and DX; pipeline inserts a bubble into XM.
- dx_kill  out  1  one-cycle pulse: the DX mul/div is retired and must become a nop when DX next advances.
- wb_req  out  1  request a regfile write slot.
- wb_reg  out  5  destination register for the write.
- wb_data  out  32  data for the write.
- wb_gnt  in  1  writeback arbiter accepts the write this cycle.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Detect: dx_valid & dx_insn[31:27]==5'b00000 & dx_insn[6:2] in {5'b00110 (mul), 5'b00111 (div)}.
- Reset: FSM to IDLE, counter 0, all outputs 0, latched registers 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - stall = detect, combinational, the same cycle.
  - On detect: latch dx_a, dx_b, rd = dx_insn[26:22] and kind (mul/div); go to ISSUE.
- ISSUE:
  - Exactly one of md_mult/md_div high for this single cycle; stall=1.
  - Counter cleared; go to WAIT.
- WAIT:
  - stall=1; counter increments by 1 each cycle.
  - md_rdy high: capture md_result and md_exception; go to DONE.
  - Counter==TIMEOUT without md_rdy: force exception=1; go to DONE.
  - md_rdy in the same cycle as timeout: md_rdy wins.
  - md_rdy outside WAIT is ignored.
- DONE:
  - wb_req=1; stall=1.
  - No exception: wb_reg=rd, wb_data=result.
  - Exception: wb_reg=5'd30, wb_data=32'd4 for mul, 32'd5 for div.
  - wb_req, wb_reg and wb_data hold until wb_gnt.
  - On wb_gnt: dx_kill=1 and stall=0 in that same cycle; go to IDLE.
- rd==0 with no exception: DONE skips wb_req, pulses dx_kill with stall=0 for one cycle, returns to IDLE. r0 is never written.
- Back-to-back: after dx_kill, DX holds the nop. A following mul/div is detected when it reaches DX, earliest 2 cycles after the kill.
- Latency: result written at least 3 cycles after detect plus the unit's latency; only one operation in flight.
- reset mid-operation: returns to IDLE next edge; no strobe, write or kill is issued; the external unit is abandoned.
- busy = (state != IDLE).

Optional Feature:
- Macro: MULTDIV_FASTPATH_EN.
- Defined, in IDLE on detect:
  - mul with dx_a==0 or dx_b==0: result=0; go directly to DONE with no strobe.
  - div with dx_b==0: exception=1; go directly to DONE with no strobe.
  - div with dx_a==0: result=0; go directly to DONE with no strobe.
- Undefined: every detected op passes through ISSUE and WAIT.

Test Plan:
- mul, rd=3, A=6, B=7; unit returns 42 after 17 cycles -> one md_mult pulse; stall held; wb_req with wb_reg=3, wb_data=42; with wb_gnt tied high, dx_kill pulses and stall drops the same cycle.
- div, A=100, B=0; unit asserts md_exception with md_rdy -> wb_reg=30, wb_data=5; rd is never written.
- mul with md_rdy never asserted, TIMEOUT=40 -> DONE entered after 40 WAIT cycles; wb_reg=30, wb_data=4.
- mul, rd=0, A=2, B=2 -> no wb_req; single dx_kill pulse; FSM back in IDLE.
- reset asserted mid-WAIT, then the unit raises md_rdy -> all outputs 0; md_rdy ignored; no write and no kill.
- wb_gnt held low 5 cycles in DONE -> wb_req, wb_reg, wb_data and stall stable for all 5 cycles; completes on the first wb_gnt.
